// File: rtl/hex_display_ctrl.sv
// Multi-digit seven-segment controller: latches a hex value and blank mask,
// adds leading-zero blanking and a blink mode, and drives registered segments.
// Ports: clock, reset (sync, active-high), load, value, blank_mask, lzb_en,
//        blink_en in; segments (7 bits per digit, gfedcba), blink_phase out.
module hex_display_ctrl #(
  parameter int DIGITS     = 6,
  parameter int BLINK_DIV  = 25_000_000,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     blank_mask,
  input  logic                  lzb_en,
  input  logic                  blink_en,
  output logic [7*DIGITS-1:0]   segments,
  output logic                  blink_phase
);

  if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
    $error("hex_display_ctrl: DIGITS must be 1..8");
  end
  if (BLINK_DIV < 2) begin : g_bad_div
    $error("hex_display_ctrl: BLINK_DIV must be >= 2");
  end

  localparam int CW = (BLINK_DIV >= 2) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BLINK_DIV - 1);
  localparam logic [6:0] DARK = ACTIVE_LOW ? 7'h7F : 7'h00;

  // Active-low gfedcba code for one hex digit.
  function automatic logic [6:0] hex7(input logic [3:0] d);
    logic [6:0] c;
    unique case (d)
      4'h0: c = 7'h40;
      4'h1: c = 7'h79;
      4'h2: c = 7'h24;
      4'h3: c = 7'h30;
      4'h4: c = 7'h19;
      4'h5: c = 7'h12;
      4'h6: c = 7'h02;
      4'h7: c = 7'h78;
      4'h8: c = 7'h00;
      4'h9: c = 7'h18;
      4'hA: c = 7'h08;
      4'hB: c = 7'h03;
      4'hC: c = 7'h46;
      4'hD: c = 7'h21;
      4'hE: c = 7'h06;
      default: c = 7'h0E;
    endcase
    return c;
  endfunction

  logic [4*DIGITS-1:0] value_q, value_d;
  logic [DIGITS-1:0]   mask_q, mask_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                phase_q, phase_d;
  logic [7*DIGITS-1:0] seg_q, seg_d;
  logic [DIGITS-1:0]   lz_dark;
  logic                seen;

  always_comb begin
    value_d = value_q;
    mask_d  = mask_q;
    if (load) begin
      value_d = value;
      mask_d  = blank_mask;
    end
  end

  // Blink: counter runs only while enabled; phase flips on each wrap.
  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (!blink_en) begin
      cnt_d   = '0;
      phase_d = 1'b0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Scan from the top digit; zeros stay dark until a nonzero digit is seen.
  // Digit 0 is never part of the scan so a zero value still shows "0".
  always_comb begin
    lz_dark = '0;
    seen    = 1'b0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      if (value_q[4*i +: 4] != 4'h0) seen = 1'b1;
      lz_dark[i] = lzb_en && !seen;
    end
  end

  // Blink uses the next phase so segments and blink_phase change together.
  always_comb begin
    seg_d = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (phase_d || mask_q[i] || lz_dark[i]) begin
        seg_d[7*i +: 7] = DARK;
      end else if (ACTIVE_LOW) begin
        seg_d[7*i +: 7] = hex7(value_q[4*i +: 4]);
      end else begin
        seg_d[7*i +: 7] = ~hex7(value_q[4*i +: 4]);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      value_q <= '0;
      mask_q  <= '0;
      cnt_q   <= '0;
      phase_q <= 1'b0;
      seg_q   <= {DIGITS{DARK}};
    end else begin
      value_q <= value_d;
      mask_q  <= mask_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      seg_q   <= seg_d;
    end
  end

  assign segments    = seg_q;
  assign blink_phase = phase_q;

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Bench for hex_display_ctrl (DIGITS=6, BLINK_DIV=4, ACTIVE_LOW=1):
// vector table, blink corner sequences, then random stimulus vs a model.
module tb_hex_display_ctrl;

  localparam int DIV = 4;

  logic        clock = 1'b0;
  logic        reset, load, lzb_en, blink_en;
  logic [23:0] value;
  logic [5:0]  blank_mask;
  logic [41:0] segments;
  logic        blink_phase;

  hex_display_ctrl #(.DIGITS(6), .BLINK_DIV(DIV), .ACTIVE_LOW(1'b1)) dut (
    .clock(clock), .reset(reset), .load(load), .value(value),
    .blank_mask(blank_mask), .lzb_en(lzb_en), .blink_en(blink_en),
    .segments(segments), .blink_phase(blink_phase)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  logic [6:0] codes [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12,
    7'h02, 7'h78, 7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  localparam logic [41:0] ALL_DARK = {6{7'h7F}};

  // Model state: latched value/mask and consecutive blink-enabled edges.
  logic [23:0] mv;
  logic [5:0]  mm;
  int          run;
  logic [41:0] exp_seg;
  logic        exp_ph;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [41:0] model_seg(input logic [23:0] v,
      input logic [5:0] m, input logic lz);
    logic [41:0] s;
    int lead;
    lead = 0;
    for (int i = 0; i < 6; i++)
      if (((v >> (4 * i)) & 24'hF) != 0) lead = i;
    for (int i = 0; i < 6; i++) begin
      if (m[i] || (lz && i > lead)) s[7*i +: 7] = 7'h7F;
      else s[7*i +: 7] = codes[(v >> (4 * i)) & 24'hF];
    end
    return s;
  endfunction

  task automatic step(input logic r, input logic ld, input logic [23:0] v,
      input logic [5:0] m, input logic lz, input logic bl);
    reset = r; load = ld; value = v; blank_mask = m;
    lzb_en = lz; blink_en = bl;
    @(posedge clock);
    if (r) begin
      exp_seg = ALL_DARK; exp_ph = 1'b0; run = 0; mv = '0; mm = '0;
    end else begin
      run     = bl ? run + 1 : 0;
      exp_ph  = ((run / DIV) % 2) == 1;
      exp_seg = exp_ph ? ALL_DARK : model_seg(mv, mm, lz);
      if (ld) begin mv = v; mm = m; end
    end
    #1;
    check("model_seg", 64'(segments), 64'(exp_seg));
    check("model_phase", 64'(blink_phase), 64'(exp_ph));
  endtask

  typedef struct {
    logic        r, ld;
    logic [23:0] v;
    logic [5:0]  m;
    logic        lz;
    logic [41:0] seg;
    logic        ph;
  } vec_t;

  vec_t vecs [9];

  initial begin
    mv = '0; mm = '0; run = 0; exp_seg = ALL_DARK; exp_ph = 1'b0;

    vecs[0] = '{1'b1, 1'b1, 24'h123456, 6'h00, 1'b0, ALL_DARK, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 24'h123456, 6'h00, 1'b0, ALL_DARK, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 24'h0ABC9F, 6'h00, 1'b0, {6{7'h40}}, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 24'h0ABC9F, 6'h00, 1'b0,
      {7'h40, 7'h08, 7'h03, 7'h46, 7'h18, 7'h0E}, 1'b0};
    vecs[4] = '{1'b0, 1'b1, 24'h000070, 6'h00, 1'b1,
      {7'h7F, 7'h08, 7'h03, 7'h46, 7'h18, 7'h0E}, 1'b0};
    vecs[5] = '{1'b0, 1'b1, 24'h000000, 6'h00, 1'b1,
      {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h78, 7'h40}, 1'b0};
    vecs[6] = '{1'b0, 1'b1, 24'hFFFFFF, 6'b000101, 1'b1,
      {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40}, 1'b0};
    vecs[7] = '{1'b0, 1'b0, 24'h0, 6'h00, 1'b1,
      {7'h0E, 7'h0E, 7'h0E, 7'h7F, 7'h0E, 7'h7F}, 1'b0};
    vecs[8] = '{1'b0, 1'b0, 24'h0, 6'h00, 1'b0,
      {7'h0E, 7'h0E, 7'h0E, 7'h7F, 7'h0E, 7'h7F}, 1'b0};

    for (int k = 0; k < 9; k++) begin
      step(vecs[k].r, vecs[k].ld, vecs[k].v, vecs[k].m, vecs[k].lz, 1'b0);
      check($sformatf("vec%0d_seg", k), 64'(segments), 64'(vecs[k].seg));
      check($sformatf("vec%0d_phase", k), 64'(blink_phase), 64'(vecs[k].ph));
    end

    // Blink: load 0x012345, then dark after the 4th enabled edge.
    step(1'b0, 1'b1, 24'h012345, 6'h00, 1'b0, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      step(1'b0, 1'b0, 24'h0, 6'h00, 1'b0, 1'b1);
      check($sformatf("blink_ph_k%0d", k), 64'(blink_phase),
            64'((k >= 4) ? 1 : 0));
      if (k >= 4) check("blink_dark", 64'(segments), 64'(ALL_DARK));
    end
    // Drop blink_en in the dark half: restored on the very next edge.
    step(1'b0, 1'b0, 24'h0, 6'h00, 1'b0, 1'b0);
    check("blink_drop_ph", 64'(blink_phase), 64'(0));
    check("blink_drop_seg", 64'(segments),
          64'({7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12}));

    // Load on the wrap edge: new value stays hidden until phase returns to 0.
    for (int k = 1; k <= 8; k++) begin
      step(1'b0, k == 4, 24'h00ABCD, 6'h00, 1'b0, 1'b1);
      if (k >= 5 && k <= 7)
        check("wrap_load_dark", 64'(segments), 64'(ALL_DARK));
    end
    check("wrap_load_ph", 64'(blink_phase), 64'(0));
    check("wrap_load_seg", 64'(segments),
          64'({7'h40, 7'h40, 7'h08, 7'h03, 7'h46, 7'h21}));

    // Random traffic; blink_en held in stretches so phases get exercised.
    begin
      logic bl;
      logic [23:0] rv;
      logic [5:0] rm;
      bl = 1'b0;
      for (int n = 0; n < 400; n++) begin
        if ($urandom_range(0, 19) == 0) bl = ~bl;
        rv = 24'($urandom) & (24'hFFFFFF >> (4 * $urandom_range(0, 6)));
        rm = ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'h00;
        step($urandom_range(0, 49) == 0, $urandom_range(0, 2) == 0,
             rv, rm, 1'($urandom), bl);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
